// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard detection, operand forwarding and halt/drain sequencing for a 5-stage pipeline.
// Defining PIPELINE_CTRL_PERF_CNT_EN adds free-running stall and flush performance counters.
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  i_rs1_D,
   input  logic [4:0]  i_rs2_D,
   input  logic        i_branch_D,
   input  logic        i_branch_eq_D,
   input  logic [4:0]  i_rs1_E,
   input  logic [4:0]  i_rs2_E,
   input  logic [4:0]  i_register_file_wr_addr_E,
   input  logic        i_register_file_wr_en_E,
   input  logic        i_sel_result_E,
   input  logic [4:0]  i_register_file_wr_addr_M,
   input  logic        i_register_file_wr_en_M,
   input  logic        i_sel_result_M,
   input  logic [4:0]  i_register_file_wr_addr_W,
   input  logic        i_register_file_wr_en_W,
   input  logic        i_halt,
   output logic        o_en_F,
   output logic        o_en_D,
   output logic        o_clr_D,
   output logic        o_clr_E,
   output logic        o_sel_PC_D,
   output logic        o_fwdA_D,
   output logic        o_fwdB_D,
   output logic [1:0]  o_fwdA_E,
   output logic [1:0]  o_fwdB_E,
   output logic        o_halted
`ifdef PIPELINE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t      state_r;
   logic        init_cnt_r;
   logic [1:0]  drain_cnt_r;
   logic        load_use_s;
   logic        branch_stall_s;
   logic        stall_s;
   logic        fwd_a_d_s;
   logic        fwd_b_d_s;
   logic [1:0]  fwd_a_e_s;
   logic [1:0]  fwd_b_e_s;

   // A producer matches a consumer only if it writes a non-zero register of the same index.
   function automatic logic hit(input logic en, input logic [4:0] wa, input logic [4:0] ra);
      return en && (wa != 5'd0) && (wa == ra);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic m_en, input logic [4:0] m_wa,
                                          input logic w_en, input logic [4:0] w_wa,
                                          input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (hit(m_en, m_wa, rs)) begin
         sel = 2'b10;
      end else if (hit(w_en, w_wa, rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection and forwarding selects
   always_comb begin
      load_use_s     = i_sel_result_E &
                       (hit(i_register_file_wr_en_E, i_register_file_wr_addr_E, i_rs1_D) |
                        hit(i_register_file_wr_en_E, i_register_file_wr_addr_E, i_rs2_D));
      branch_stall_s = i_branch_D &
                       (hit(i_register_file_wr_en_E, i_register_file_wr_addr_E, i_rs1_D) |
                        hit(i_register_file_wr_en_E, i_register_file_wr_addr_E, i_rs2_D) |
                        (i_sel_result_M &
                         (hit(i_register_file_wr_en_M, i_register_file_wr_addr_M, i_rs1_D) |
                          hit(i_register_file_wr_en_M, i_register_file_wr_addr_M, i_rs2_D))));
      stall_s        = rst & (state_r == ST_RUN) & (load_use_s | branch_stall_s);
      fwd_a_d_s      = hit(i_register_file_wr_en_M, i_register_file_wr_addr_M, i_rs1_D);
      fwd_b_d_s      = hit(i_register_file_wr_en_M, i_register_file_wr_addr_M, i_rs2_D);
      fwd_a_e_s      = fwd_sel(i_register_file_wr_en_M, i_register_file_wr_addr_M,
                               i_register_file_wr_en_W, i_register_file_wr_addr_W, i_rs1_E);
      fwd_b_e_s      = fwd_sel(i_register_file_wr_en_M, i_register_file_wr_addr_M,
                               i_register_file_wr_en_W, i_register_file_wr_addr_W, i_rs2_E);
   end

   // Pipeline control outputs; reset overrides combinationally so they are safe before the first edge
   always_comb begin
      o_en_F     = 1'b0;
      o_en_D     = 1'b0;
      o_clr_D    = 1'b1;
      o_clr_E    = 1'b1;
      o_sel_PC_D = 1'b0;
      o_fwdA_D   = 1'b0;
      o_fwdB_D   = 1'b0;
      o_fwdA_E   = 2'b00;
      o_fwdB_E   = 2'b00;
      o_halted   = 1'b0;
      if (rst) begin
         case (state_r)
            ST_INIT: begin
               o_clr_D = 1'b1;
            end
            ST_RUN: begin
               o_en_F     = ~stall_s;
               o_en_D     = ~stall_s;
               o_clr_E    = stall_s;
               o_sel_PC_D = i_branch_D & i_branch_eq_D & ~stall_s;
               o_clr_D    = i_branch_D & i_branch_eq_D & ~stall_s;
               o_fwdA_D   = fwd_a_d_s;
               o_fwdB_D   = fwd_b_d_s;
               o_fwdA_E   = fwd_a_e_s;
               o_fwdB_E   = fwd_b_e_s;
            end
            ST_DRAIN: begin
               o_clr_D  = 1'b0;
               o_fwdA_D = fwd_a_d_s;
               o_fwdB_D = fwd_b_d_s;
               o_fwdA_E = fwd_a_e_s;
               o_fwdB_E = fwd_b_e_s;
            end
            ST_HALTED: begin
               o_clr_D  = 1'b0;
               o_halted = 1'b1;
            end
            default: begin
               o_clr_D = 1'b1;
            end
         endcase
      end else begin
         o_clr_D = 1'b1;
         o_clr_E = 1'b1;
      end
   end

   // Sequencing FSM: 2-cycle init, run, 3-cycle drain, halted
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_INIT;
         init_cnt_r  <= 1'b0;
         drain_cnt_r <= 2'd0;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (init_cnt_r) begin
                  state_r <= ST_RUN;
               end else begin
                  init_cnt_r <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_halt && !stall_s) begin
                  state_r     <= ST_DRAIN;
                  drain_cnt_r <= 2'd0;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r == 2'd2) begin
                  state_r <= ST_HALTED;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 2'd1;
               end
            end
            ST_HALTED: begin
               if (!i_halt) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_HALTED;
               end
            end
            default: begin
               state_r <= ST_INIT;
            end
         endcase
      end
   end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
   // Performance counters, wrapping naturally at 32 bits
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_stall_cnt <= 32'd0;
         o_flush_cnt <= 32'd0;
      end else begin
         if (stall_s) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
         end else begin
            o_stall_cnt <= o_stall_cnt;
         end
         if (o_sel_PC_D) begin
            o_flush_cnt <= o_flush_cnt + 32'd1;
         end else begin
            o_flush_cnt <= o_flush_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed pins plus randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, wa_E, wa_M, wa_W;
   logic       branch_D, beq_D, wen_E, sel_E, wen_M, sel_M, wen_W, halt;
   logic       en_F, en_D, clr_D, clr_E, sel_PC, fwdA_D, fwdB_D, halted;
   logic [1:0] fwdA_E, fwdB_E;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
   logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // model state: cycles of init left, drain cycles left, halted flag
   int m_init_left  = 2;
   int m_drain_left = 0;
   bit m_halted     = 0;
   bit e_run, e_stall;
   logic       e_en_F, e_en_D, e_clr_D, e_clr_E, e_sel, e_fA_D, e_fB_D, e_halted;
   logic [1:0] e_fA_E, e_fB_E;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .i_rs1_D(rs1_D), .i_rs2_D(rs2_D), .i_branch_D(branch_D), .i_branch_eq_D(beq_D),
      .i_rs1_E(rs1_E), .i_rs2_E(rs2_E),
      .i_register_file_wr_addr_E(wa_E), .i_register_file_wr_en_E(wen_E), .i_sel_result_E(sel_E),
      .i_register_file_wr_addr_M(wa_M), .i_register_file_wr_en_M(wen_M), .i_sel_result_M(sel_M),
      .i_register_file_wr_addr_W(wa_W), .i_register_file_wr_en_W(wen_W),
      .i_halt(halt),
      .o_en_F(en_F), .o_en_D(en_D), .o_clr_D(clr_D), .o_clr_E(clr_E), .o_sel_PC_D(sel_PC),
      .o_fwdA_D(fwdA_D), .o_fwdB_D(fwdB_D), .o_fwdA_E(fwdA_E), .o_fwdB_E(fwdB_E),
      .o_halted(halted)
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      ,
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   function automatic bool_writes(input logic en, input logic [4:0] wa, input logic [4:0] rd);
      return en && (wa != 5'd0) && (wa == rd);
   endfunction

   function automatic logic [1:0] model_fwd_e(input logic [4:0] rs);
      if (bool_writes(wen_M, wa_M, rs)) return 2'b10;
      if (bool_writes(wen_W, wa_W, rs)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic compute_expect();
      logic [4:0] src [2];
      bit lu, br, in_init, in_drain, in_halt;
      src[0] = rs1_D;
      src[1] = rs2_D;
      lu = 0;
      br = 0;
      for (int k = 0; k < 2; k++) begin
         if (sel_E && bool_writes(wen_E, wa_E, src[k])) lu = 1;
         if (branch_D && (bool_writes(wen_E, wa_E, src[k]) || (sel_M && bool_writes(wen_M, wa_M, src[k])))) br = 1;
      end
      in_init  = (m_init_left > 0);
      in_drain = !in_init && (m_drain_left > 0);
      in_halt  = !in_init && !in_drain && m_halted;
      e_run    = rst && !in_init && !in_drain && !in_halt;
      e_stall  = e_run && (lu || br);
      {e_en_F, e_en_D, e_clr_D, e_clr_E, e_sel, e_fA_D, e_fB_D, e_halted} = 8'b0011_0000;
      e_fA_E = 2'b00;
      e_fB_E = 2'b00;
      if (rst && !in_init) begin
         e_clr_D = 1'b0;
         if (e_run || in_drain) begin
            e_fA_D = bool_writes(wen_M, wa_M, rs1_D);
            e_fB_D = bool_writes(wen_M, wa_M, rs2_D);
            e_fA_E = model_fwd_e(rs1_E);
            e_fB_E = model_fwd_e(rs2_E);
         end
         if (e_run) begin
            e_en_F  = !e_stall;
            e_en_D  = !e_stall;
            e_clr_E = e_stall;
            e_sel   = branch_D && beq_D && !e_stall;
            e_clr_D = e_sel;
         end
         e_halted = in_halt;
      end
   endtask

   // wait to mid-cycle and compare every output to the model
   task automatic observe();
      @(negedge clk);
      compute_expect();
      check("en_F", 32'(en_F), 32'(e_en_F));
      check("en_D", 32'(en_D), 32'(e_en_D));
      check("clr_D", 32'(clr_D), 32'(e_clr_D));
      check("clr_E", 32'(clr_E), 32'(e_clr_E));
      check("sel_PC_D", 32'(sel_PC), 32'(e_sel));
      check("fwdA_D", 32'(fwdA_D), 32'(e_fA_D));
      check("fwdB_D", 32'(fwdB_D), 32'(e_fB_D));
      check("fwdA_E", 32'(fwdA_E), 32'(e_fA_E));
      check("fwdB_E", 32'(fwdB_E), 32'(e_fB_E));
      check("halted", 32'(halted), 32'(e_halted));
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      check("stall_cnt", stall_cnt, m_stall_cnt);
      check("flush_cnt", flush_cnt, m_flush_cnt);
`endif
   endtask

   // clock edge: advance the model with the inputs that were sampled
   task automatic advance();
      @(posedge clk);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      if (!rst) begin
         m_stall_cnt = 32'd0;
         m_flush_cnt = 32'd0;
      end else begin
         m_stall_cnt = m_stall_cnt + 32'(e_stall);
         m_flush_cnt = m_flush_cnt + 32'(e_sel);
      end
`endif
      if (!rst) begin
         m_init_left  = 2;
         m_drain_left = 0;
         m_halted     = 0;
      end else if (m_init_left > 0) begin
         m_init_left--;
      end else if (m_drain_left > 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1;
      end else if (m_halted) begin
         if (!halt) m_halted = 0;
      end else if (halt && !e_stall) begin
         m_drain_left = 3;
      end
      #1;
   endtask

   task automatic clear_inputs();
      {rs1_D, rs2_D, rs1_E, rs2_E, wa_E, wa_M, wa_W} = '0;
      {branch_D, beq_D, wen_E, sel_E, wen_M, sel_M, wen_W, halt} = '0;
   endtask

   task automatic rand_inputs();
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
      wa_E  = 5'($urandom_range(0, 3)); wa_M  = 5'($urandom_range(0, 3));
      wa_W  = 5'($urandom_range(0, 3));
      branch_D = 1'($urandom_range(0, 1)); beq_D = 1'($urandom_range(0, 1));
      wen_E = 1'($urandom_range(0, 1)); sel_E = 1'($urandom_range(0, 1));
      wen_M = 1'($urandom_range(0, 1)); sel_M = 1'($urandom_range(0, 1));
      wen_W = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      rst = ($urandom_range(0, 149) != 0);
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
`endif
      observe();
      check("pin_rst_clrD", 32'(clr_D), 32'd1);
      check("pin_rst_halted", 32'(halted), 32'd0);
      advance();
      rst = 1'b1;
      observe(); check("pin_init1_enF", 32'(en_F), 32'd0); advance();
      observe(); check("pin_init2_enF", 32'(en_F), 32'd0); advance();
      observe(); check("pin_run_enF", 32'(en_F), 32'd1); advance();

      // load-use on x5
      wen_E = 1'b1; sel_E = 1'b1; wa_E = 5'd5; rs1_D = 5'd5;
      observe();
      check("pin_lu_enF", 32'(en_F), 32'd0);
      check("pin_lu_enD", 32'(en_D), 32'd0);
      check("pin_lu_clrE", 32'(clr_E), 32'd1);
      advance();
      clear_inputs();
      observe(); check("pin_lu_after", 32'(en_F), 32'd1); advance();

      // execute forwarding priority
      wen_M = 1'b1; wa_M = 5'd3; wen_W = 1'b1; wa_W = 5'd3; rs1_E = 5'd3;
      observe(); check("pin_fwd_M", 32'(fwdA_E), 32'd2); advance();
      wen_M = 1'b0;
      observe(); check("pin_fwd_W", 32'(fwdA_E), 32'd1); advance();
      wen_M = 1'b1; wa_M = 5'd0; wa_W = 5'd0; rs1_E = 5'd0;
      observe(); check("pin_fwd_x0", 32'(fwdA_E), 32'd0); advance();
      clear_inputs();

      // taken branch, then same branch against a dependency
      branch_D = 1'b1; beq_D = 1'b1; rs1_D = 5'd1; rs2_D = 5'd7;
      observe();
      check("pin_br_sel", 32'(sel_PC), 32'd1);
      check("pin_br_clrD", 32'(clr_D), 32'd1);
      advance();
      wen_E = 1'b1; wa_E = 5'd7;
      observe();
      check("pin_brst_sel", 32'(sel_PC), 32'd0);
      check("pin_brst_clrD", 32'(clr_D), 32'd0);
      check("pin_brst_enF", 32'(en_F), 32'd0);
      advance();
      clear_inputs();

      // halt: 3 drain cycles, halted on the 4th, resume
      halt = 1'b1;
      observe(); check("pin_halt_req", 32'(halted), 32'd0); advance();
      for (int i = 0; i < 3; i++) begin
         observe();
         check("pin_drain_halted", 32'(halted), 32'd0);
         check("pin_drain_enF", 32'(en_F), 32'd0);
         advance();
      end
      observe(); check("pin_halted", 32'(halted), 32'd1); advance();
      halt = 1'b0;
      observe(); check("pin_halted_hold", 32'(halted), 32'd1); advance();
      observe();
      check("pin_resume_halted", 32'(halted), 32'd0);
      check("pin_resume_enF", 32'(en_F), 32'd1);
      advance();

      // reset in the middle of drain
      halt = 1'b1;
      observe(); advance();
      observe(); advance();
      rst = 1'b0;
      observe(); check("pin_drst_halted", 32'(halted), 32'd0); advance();
      rst = 1'b1;
      observe();
      check("pin_drst_init", 32'(en_F), 32'd0);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      check("pin_drst_stallcnt", stall_cnt, 32'd0);
      check("pin_drst_flushcnt", flush_cnt, 32'd0);
`endif
      advance();
      halt = 1'b0;

      for (int n = 0; n < 4000; n++) begin
         rand_inputs();
         observe();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide ports: clk  in  1  single clock, all state updates on rising edge; rst  in  1  reset, synchronous, active-low.
REQ-002 SHALL provide decode-stage inputs: i_rs1_D, i_rs2_D  in  5 each  source register addresses; i_branch_D  in  1  branch in decode; i_branch_eq_D  in  1  branch compare result.
REQ-003 SHALL provide execute-stage inputs: i_rs1_E, i_rs2_E  in  5 each; i_register_file_wr_addr_E  in  5; i_register_file_wr_en_E  in  1; i_sel_result_E  in  1  (1 = load).
REQ-004 SHALL provide memory-stage inputs: i_register_file_wr_addr_M  in  5; i_register_file_wr_en_M  in  1; i_sel_result_M  in  1  (1 = load).
REQ-005 SHALL provide writeback-stage inputs: i_register_file_wr_addr_W  in  5; i_register_file_wr_en_W  in  1.
REQ-006 SHALL provide debug inputs: i_halt  in  1  halt request, level-sensitive.
REQ-007 SHALL provide outputs: o_en_F  1  fetch PC enable; o_en_D  1  F/D register enable; o_clr_D  1  F/D flush; o_clr_E  1  D/E flush; o_sel_PC_D  1  take branch target; o_fwdA_D, o_fwdB_D  1 each  decode forward from M; o_fwdA_E, o_fwdB_E  2 each  execute forward select; o_halted  1  pipeline drained and frozen.

Function
REQ-010 SHALL implement FSM states INIT, RUN, DRAIN, HALTED; encoding implementation-defined.
REQ-011 INIT: SHALL hold o_en_F=0, o_en_D=0, o_clr_D=1, o_clr_E=1 for exactly 2 cycles after reset release, then enter RUN.
REQ-012 RUN: o_fwdA_E SHALL be 2'b10 when i_register_file_wr_en_M=1, wr_addr_M!=0, wr_addr_M==i_rs1_E; else 2'b01 for same match against W; else 2'b00; M has priority over W. o_fwdB_E likewise on i_rs2_E.
REQ-013 RUN: o_fwdA_D SHALL be 1 when wr_en_M=1, wr_addr_M!=0, wr_addr_M==i_rs1_D; o_fwdB_D likewise on i_rs2_D.
REQ-014 Load-use stall SHALL assert when i_sel_result_E=1, wr_en_E=1, wr_addr_E!=0 and wr_addr_E equals i_rs1_D or i_rs2_D.
REQ-015 Branch stall SHALL assert when i_branch_D=1 and either (wr_en_E=1, wr_addr_E!=0, matching i_rs1_D/i_rs2_D) or (i_sel_result_M=1, wr_en_M=1, wr_addr_M!=0, matching i_rs1_D/i_rs2_D).
REQ-016 Any stall SHALL drive o_en_F=0, o_en_D=0, o_clr_E=1 combinationally in the same cycle.
REQ-017 o_sel_PC_D SHALL equal i_branch_D & i_branch_eq_D & ~stall; o_clr_D SHALL equal o_sel_PC_D in RUN.
REQ-018 Stall and taken branch simultaneous: stall SHALL win; o_sel_PC_D=0, o_clr_D=0.
REQ-019 RUN with i_halt=1 and no stall: SHALL enter DRAIN next cycle; with stall active, transition SHALL defer until stall clears.
REQ-020 DRAIN: SHALL hold o_en_F=0, o_en_D=0, o_clr_E=1, forwarding per REQ-012/013 for exactly 3 cycles, then enter HALTED.
REQ-021 HALTED: SHALL hold o_en_F=0, o_en_D=0, o_clr_E=1, o_halted=1; on i_halt=0 SHALL enter RUN next cycle with o_halted=0.
REQ-022 i_halt deasserted during DRAIN SHALL NOT abort drain; HALTED SHALL still be reached, then exit per REQ-021.
REQ-023 o_halted SHALL be 0 in every state except HALTED.

Reset
REQ-030 rst=0 sampled at rising edge SHALL force INIT, clear drain counter and init counter, in any state including mid-DRAIN.
REQ-031 While rst=0 outputs SHALL be: o_en_F=0, o_en_D=0, o_clr_D=1, o_clr_E=1, o_sel_PC_D=0, all fwd=0, o_halted=0.

Configuration
REQ-040 Macro PIPELINE_CTRL_PERF_CNT_EN defined SHALL add outputs o_stall_cnt (32) and o_flush_cnt (32): stall count increments per RUN cycle with stall, flush count per cycle with o_sel_PC_D=1; both wrap at 2^32-1 to 0, reset to 0.
REQ-041 Macro undefined SHALL omit both ports and counters; all other behaviour identical.

Verification
REQ-050 Reset release -> o_en_F=0 for cycles 1-2, o_en_F=1 on cycle 3 with no hazards.
REQ-051 E: load x5 (wr_en_E=1, sel_result_E=1, addr 5); D: rs1=5 -> one cycle o_en_F=0, o_en_D=0, o_clr_E=1; next cycle no stall.
REQ-052 M writes x3, W writes x3, rs1_E=3 -> o_fwdA_E=2'b10; M wr_en=0 -> 2'b01; addr 0 everywhere -> 2'b00.
REQ-053 i_branch_D=1, i_branch_eq_D=1, no dependency -> o_sel_PC_D=1, o_clr_D=1; same with wr_addr_E=rs2_D=7 -> o_sel_PC_D=0, stall.
REQ-054 i_halt=1 in RUN -> DRAIN 3 cycles, o_halted=1 on 4th; i_halt=0 -> o_halted=0, o_en_F=1 next cycle.
REQ-055 rst=0 during DRAIN cycle 2 -> INIT, o_halted=0; with PIPELINE_CTRL_PERF_CNT_EN, counters read 0.
